// File: rtl/stage_envelope_generator_pkg.sv
// Shared types and constants for the envelope generator stage.
package stage_envelope_generator_pkg;

  localparam int DEFAULT_NUM_VOICES          = 8;
  localparam int DEFAULT_NUM_OPERATORS       = 4;
  localparam int DEFAULT_NUM_VOICE_OPERATORS = DEFAULT_NUM_VOICES * DEFAULT_NUM_OPERATORS;
  localparam int DEFAULT_VOP_ID_WIDTH        = $clog2(DEFAULT_NUM_VOICE_OPERATORS);
  localparam int DEFAULT_VOICE_ID_WIDTH      = $clog2(DEFAULT_NUM_VOICES);

  localparam logic [15:0] ENVELOPE_MAX = 16'hFFFF;

  typedef logic [DEFAULT_VOP_ID_WIDTH-1:0]   vop_id_t;
  typedef logic [DEFAULT_VOICE_ID_WIDTH-1:0] voice_id_t;

  typedef enum logic [2:0] {
    ENV_IDLE    = 3'd0,
    ENV_ATTACK  = 3'd1,
    ENV_DECAY   = 3'd2,
    ENV_SUSTAIN = 3'd3,
    ENV_RELEASE = 3'd4
  } envelope_state_t;

  // Voice-operator IDs are laid out voice-major: id = voice * NUM_OPERATORS + operator.
  function automatic voice_id_t getVoiceID(input vop_id_t voiceOperator);
    return voice_id_t'(voiceOperator / vop_id_t'(DEFAULT_NUM_OPERATORS));
  endfunction

endpackage

// File: rtl/envelope_next_state.sv
// Combinational ADSR step: given one operator's current state, level,
// note edges and rates, produce the state and level after this visit.
module envelope_next_state
  import stage_envelope_generator_pkg::*;
(
  input  envelope_state_t state,
  input  logic [15:0]     level,
  input  logic            rise,
  input  logic            fall,
  input  logic [15:0]     attackRate,
  input  logic [15:0]     decayRate,
  input  logic [15:0]     sustainLevel,
  input  logic [15:0]     releaseRate,
  output envelope_state_t nextState,
  output logic [15:0]     nextLevel
);

  envelope_state_t entryState;
  logic [16:0]     attackSum;
  logic [16:0]     decayDiff;
  logic [16:0]     releaseDiff;

  // 17-bit intermediates so saturation and underflow are visible, never wrapped.
  assign attackSum   = {1'b0, level} + {1'b0, attackRate};
  assign decayDiff   = {1'b0, level} - {1'b0, decayRate};
  assign releaseDiff = {1'b0, level} - {1'b0, releaseRate};

  // Note edges override the stored state; a retrigger keeps the current level.
  always_comb begin
    entryState = state;
    if (rise) begin
      entryState = ENV_ATTACK;
    end else if (fall && (state inside {ENV_ATTACK, ENV_DECAY, ENV_SUSTAIN})) begin
      entryState = ENV_RELEASE;
    end
  end

  // Apply one step of the phase the operator is in after edge handling.
  always_comb begin
    nextState = entryState;
    nextLevel = level;
    case (entryState)
      ENV_ATTACK: begin
        if ((attackRate == 16'd0) || (attackSum >= {1'b0, ENVELOPE_MAX})) begin
          nextLevel = ENVELOPE_MAX;
          nextState = ENV_DECAY;
        end else begin
          nextLevel = attackSum[15:0];
        end
      end
      ENV_DECAY: begin
        if ((decayRate == 16'd0) || decayDiff[16] || (decayDiff[15:0] <= sustainLevel)) begin
          nextLevel = sustainLevel;
          nextState = ENV_SUSTAIN;
        end else begin
          nextLevel = decayDiff[15:0];
        end
      end
      ENV_SUSTAIN: begin
        nextLevel = sustainLevel;
      end
      ENV_RELEASE: begin
        if ((releaseRate == 16'd0) || releaseDiff[16] || (releaseDiff[15:0] == 16'd0)) begin
          nextLevel = 16'd0;
          nextState = ENV_IDLE;
        end else begin
          nextLevel = releaseDiff[15:0];
        end
      end
      default: begin
        nextLevel = 16'd0;
        nextState = ENV_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/stage_envelope_generator.sv
// ADSR envelope pipeline stage. Clock 1 reads the visiting operator's state,
// level, previous note-on and rates; clock 2 registers the outputs and
// writes the updated state back. IDs must not repeat on consecutive cycles.
module stage_envelope_generator
  import stage_envelope_generator_pkg::*;
#(
  parameter int NUM_VOICES          = DEFAULT_NUM_VOICES,
  parameter int NUM_OPERATORS       = DEFAULT_NUM_OPERATORS,
  parameter int NUM_VOICE_OPERATORS = NUM_VOICES * NUM_OPERATORS,
  parameter int VOP_ID_WIDTH        = $clog2(NUM_VOICE_OPERATORS)
) (
  input  logic                    i_Clock,
  input  logic                    i_Reset_n,
  input  logic [15:0]             i_Phase,
  input  logic                    i_NoteOn,
  input  logic [VOP_ID_WIDTH-1:0] i_VoiceOperator,
  output logic [15:0]             o_Phase,
  output logic [15:0]             o_Envelope,
  output logic [VOP_ID_WIDTH-1:0] o_VoiceOperator,
  output logic                    o_EnvelopeActive,
  input  logic                    i_AttackConfigWriteEnable,
  input  logic                    i_DecayConfigWriteEnable,
  input  logic                    i_SustainConfigWriteEnable,
  input  logic                    i_ReleaseConfigWriteEnable,
  input  logic [VOP_ID_WIDTH-1:0] i_ConfigWriteAddr,
  input  logic [15:0]             i_ConfigWriteData
);

  envelope_state_t stateMem      [NUM_VOICE_OPERATORS];
  logic [15:0]     levelMem      [NUM_VOICE_OPERATORS];
  logic            prevNoteOnMem [NUM_VOICE_OPERATORS];
  logic [15:0]     attackMem     [NUM_VOICE_OPERATORS];
  logic [15:0]     decayMem      [NUM_VOICE_OPERATORS];
  logic [15:0]     sustainMem    [NUM_VOICE_OPERATORS];
  logic [15:0]     releaseMem    [NUM_VOICE_OPERATORS];

  envelope_state_t         stage1State;
  logic [15:0]             stage1Level;
  logic                    stage1PrevNoteOn;
  logic [15:0]             stage1Attack;
  logic [15:0]             stage1Decay;
  logic [15:0]             stage1Sustain;
  logic [15:0]             stage1Release;
  logic [15:0]             stage1Phase;
  logic                    stage1NoteOn;
  logic [VOP_ID_WIDTH-1:0] stage1VoiceOperator;

  logic            noteRise;
  logic            noteFall;
  envelope_state_t nextState;
  logic [15:0]     nextLevel;

  // Config writes land on the edge; a read on the same edge still sees the old value.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      for (int i = 0; i < NUM_VOICE_OPERATORS; i++) begin
        attackMem[i]  <= 16'd0;
        decayMem[i]   <= 16'd0;
        sustainMem[i] <= 16'd0;
        releaseMem[i] <= 16'd0;
      end
    end else begin
      if (i_AttackConfigWriteEnable)  attackMem[i_ConfigWriteAddr]  <= i_ConfigWriteData;
      if (i_DecayConfigWriteEnable)   decayMem[i_ConfigWriteAddr]   <= i_ConfigWriteData;
      if (i_SustainConfigWriteEnable) sustainMem[i_ConfigWriteAddr] <= i_ConfigWriteData;
      if (i_ReleaseConfigWriteEnable) releaseMem[i_ConfigWriteAddr] <= i_ConfigWriteData;
    end
  end

  // Clock 1: fetch the visiting operator's context alongside the stream inputs.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      stage1State         <= ENV_IDLE;
      stage1Level         <= 16'd0;
      stage1PrevNoteOn    <= 1'b0;
      stage1Attack        <= 16'd0;
      stage1Decay         <= 16'd0;
      stage1Sustain       <= 16'd0;
      stage1Release       <= 16'd0;
      stage1Phase         <= 16'd0;
      stage1NoteOn        <= 1'b0;
      stage1VoiceOperator <= '0;
    end else begin
      stage1State         <= stateMem[i_VoiceOperator];
      stage1Level         <= levelMem[i_VoiceOperator];
      stage1PrevNoteOn    <= prevNoteOnMem[i_VoiceOperator];
      stage1Attack        <= attackMem[i_VoiceOperator];
      stage1Decay         <= decayMem[i_VoiceOperator];
      stage1Sustain       <= sustainMem[i_VoiceOperator];
      stage1Release       <= releaseMem[i_VoiceOperator];
      stage1Phase         <= i_Phase;
      stage1NoteOn        <= i_NoteOn;
      stage1VoiceOperator <= i_VoiceOperator;
    end
  end

  assign noteRise = stage1NoteOn & ~stage1PrevNoteOn;
  assign noteFall = ~stage1NoteOn & stage1PrevNoteOn;

  envelope_next_state nextStateLogic (
    .state        (stage1State),
    .level        (stage1Level),
    .rise         (noteRise),
    .fall         (noteFall),
    .attackRate   (stage1Attack),
    .decayRate    (stage1Decay),
    .sustainLevel (stage1Sustain),
    .releaseRate  (stage1Release),
    .nextState    (nextState),
    .nextLevel    (nextLevel)
  );

  // Clock 2: register outputs and write the updated operator context back.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      for (int i = 0; i < NUM_VOICE_OPERATORS; i++) begin
        stateMem[i]      <= ENV_IDLE;
        levelMem[i]      <= 16'd0;
        prevNoteOnMem[i] <= 1'b0;
      end
      o_Phase          <= 16'd0;
      o_Envelope       <= 16'd0;
      o_VoiceOperator  <= '0;
      o_EnvelopeActive <= 1'b0;
    end else begin
      stateMem[stage1VoiceOperator]      <= nextState;
      levelMem[stage1VoiceOperator]      <= nextLevel;
      prevNoteOnMem[stage1VoiceOperator] <= stage1NoteOn;
      o_Phase          <= stage1Phase;
      o_Envelope       <= nextLevel;
      o_VoiceOperator  <= stage1VoiceOperator;
      o_EnvelopeActive <= (nextState != ENV_IDLE);
    end
  end

endmodule

// File: tb/tb_stage_envelope_generator.sv
// Self-checking bench for stage_envelope_generator: a per-slot ADSR model
// predicts every output cycle, and per-slot visit logs are pinned to
// hand-computed envelope sequences.
module tb_stage_envelope_generator;

  localparam int SLOTS     = 32;
  localparam int M_IDLE    = 0;
  localparam int M_ATTACK  = 1;
  localparam int M_DECAY   = 2;
  localparam int M_SUSTAIN = 3;
  localparam int M_RELEASE = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        resetN;
  logic [15:0] phaseIn;
  logic        noteOnIn;
  logic [4:0]  vopIn;
  logic        attackWe, decayWe, sustainWe, releaseWe;
  logic [4:0]  cfgAddr;
  logic [15:0] cfgData;
  logic [15:0] phaseOut;
  logic [15:0] envOut;
  logic [4:0]  vopOut;
  logic        activeOut;

  stage_envelope_generator dut (
    .i_Clock                    (clock),
    .i_Reset_n                  (resetN),
    .i_Phase                    (phaseIn),
    .i_NoteOn                   (noteOnIn),
    .i_VoiceOperator            (vopIn),
    .o_Phase                    (phaseOut),
    .o_Envelope                 (envOut),
    .o_VoiceOperator            (vopOut),
    .o_EnvelopeActive           (activeOut),
    .i_AttackConfigWriteEnable  (attackWe),
    .i_DecayConfigWriteEnable   (decayWe),
    .i_SustainConfigWriteEnable (sustainWe),
    .i_ReleaseConfigWriteEnable (releaseWe),
    .i_ConfigWriteAddr          (cfgAddr),
    .i_ConfigWriteData          (cfgData)
  );

  typedef struct packed {
    logic [15:0] phase;
    logic [15:0] env;
    logic [4:0]  vop;
    logic        active;
  } out_t;

  int   compared   = 0;
  int   mismatched = 0;
  bit   checkEnable = 0;
  int   logSlot = 3;
  int   rrSlot = 0;
  bit   noteOnBySlot [SLOTS];
  logic [16:0] slotLog [$];
  logic [16:0] expLog  [$];

  int   mState [SLOTS];
  int   mLevel [SLOTS];
  bit   mPrev  [SLOTS];
  int   mAttack [SLOTS];
  int   mDecay  [SLOTS];
  int   mSustain[SLOTS];
  int   mRelease[SLOTS];
  out_t pendExp;
  out_t outExp;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One visit of the ADSR rules applied to a slot, in plain integer arithmetic.
  function automatic void modelVisit(input int slot, input bit noteOn);
    int  lvl;
    int  st;
    bit  rise;
    bit  fall;
    lvl  = mLevel[slot];
    st   = mState[slot];
    rise = noteOn && !mPrev[slot];
    fall = !noteOn && mPrev[slot];
    mPrev[slot] = noteOn;
    if (rise) st = M_ATTACK;
    else if (fall && (st == M_ATTACK || st == M_DECAY || st == M_SUSTAIN)) st = M_RELEASE;
    if (st == M_ATTACK) begin
      if (mAttack[slot] == 0 || lvl + mAttack[slot] >= 65535) begin
        lvl = 65535;
        st  = M_DECAY;
      end else lvl = lvl + mAttack[slot];
    end else if (st == M_DECAY) begin
      if (mDecay[slot] == 0 || lvl - mDecay[slot] <= mSustain[slot]) begin
        lvl = mSustain[slot];
        st  = M_SUSTAIN;
      end else lvl = lvl - mDecay[slot];
    end else if (st == M_SUSTAIN) begin
      lvl = mSustain[slot];
    end else if (st == M_RELEASE) begin
      if (mRelease[slot] == 0 || lvl - mRelease[slot] <= 0) begin
        lvl = 0;
        st  = M_IDLE;
      end else lvl = lvl - mRelease[slot];
    end else begin
      lvl = 0;
    end
    mLevel[slot] = lvl;
    mState[slot] = st;
  endfunction

  // Model of the stage as seen from the ports: outputs show the visit made two clocks earlier.
  always @(posedge clock) begin
    if (!resetN) begin
      pendExp = '0;
      outExp  = '0;
      for (int s = 0; s < SLOTS; s++) begin
        mState[s] = M_IDLE; mLevel[s] = 0; mPrev[s] = 0;
        mAttack[s] = 0; mDecay[s] = 0; mSustain[s] = 0; mRelease[s] = 0;
      end
    end else begin
      outExp = pendExp;
      modelVisit(int'(vopIn), noteOnIn);
      pendExp.phase  = phaseIn;
      pendExp.env    = 16'(mLevel[vopIn]);
      pendExp.vop    = vopIn;
      pendExp.active = (mState[vopIn] != M_IDLE);
      if (attackWe)  mAttack[cfgAddr]  = int'(cfgData);
      if (decayWe)   mDecay[cfgAddr]   = int'(cfgData);
      if (sustainWe) mSustain[cfgAddr] = int'(cfgData);
      if (releaseWe) mRelease[cfgAddr] = int'(cfgData);
    end
  end

  // Compare every output cycle against the model, and log visits of the watched slot.
  always @(negedge clock) begin
    if (checkEnable) begin
      checkOutput("phase",    32'(phaseOut),  32'(outExp.phase));
      checkOutput("envelope", 32'(envOut),    32'(outExp.env));
      checkOutput("vop",      32'(vopOut),    32'(outExp.vop));
      checkOutput("active",   32'(activeOut), 32'(outExp.active));
      if (resetN && vopOut == 5'(logSlot)) slotLog.push_back({activeOut, envOut});
    end
  end

  task automatic applyStimulus(input bit rstn, input bit aWe, input bit dWe, input bit sWe,
                               input bit rWe, input logic [4:0] addr, input logic [15:0] data);
    @(negedge clock);
    resetN    = rstn;
    attackWe  = aWe;
    decayWe   = dWe;
    sustainWe = sWe;
    releaseWe = rWe;
    cfgAddr   = addr;
    cfgData   = data;
    vopIn     = 5'(rrSlot);
    noteOnIn  = noteOnBySlot[rrSlot];
    phaseIn   = 16'($urandom);
    rrSlot    = (rrSlot + 1) % SLOTS;
  endtask

  task automatic step();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 16'd0);
  endtask

  task automatic runCycles(input int n);
    repeat (n) step();
  endtask

  task automatic runRounds(input int n);
    runCycles(n * SLOTS);
  endtask

  task automatic alignTo(input int s);
    repeat (SLOTS) if (rrSlot != s) step();
  endtask

  // kind: 0 attack, 1 decay, 2 sustain, 3 release
  task automatic writeCfg(input int kind, input logic [4:0] addr, input logic [15:0] data);
    applyStimulus(1'b1, kind == 0, kind == 1, kind == 2, kind == 3, addr, data);
  endtask

  // Start watching a slot: align so its last visit is already out of the pipe.
  task automatic watchSlot(input int s);
    logSlot = s;
    alignTo((s + 5) % SLOTS);
    slotLog.delete();
  endtask

  task automatic expectVisit(input bit active, input logic [15:0] env);
    expLog.push_back({active, env});
  endtask

  task automatic checkLog(input string name);
    checkOutput({name, "_count"}, 32'(slotLog.size()), 32'(expLog.size()));
    for (int i = 0; i < expLog.size(); i++) begin
      if (i < slotLog.size()) checkOutput(name, 32'(slotLog[i]), 32'(expLog[i]));
    end
    expLog.delete();
    slotLog.delete();
  endtask

  initial begin
    resetN = 1'b0; phaseIn = 16'h1111; noteOnIn = 1'b1; vopIn = 5'd0;
    attackWe = 1'b0; decayWe = 1'b0; sustainWe = 1'b0; releaseWe = 1'b0;
    cfgAddr = 5'd0; cfgData = 16'd0;
    for (int s = 0; s < SLOTS; s++) noteOnBySlot[s] = 1'b1;
    @(posedge clock);
    checkEnable = 1;

    $display("[TB] reset with live stimulus");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 16'hFFFF);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 16'hFFFF);
    checkOutput("reset_env",    32'(envOut),    32'h0);
    checkOutput("reset_active", 32'(activeOut), 32'h0);
    checkOutput("reset_phase",  32'(phaseOut),  32'h0);
    checkOutput("reset_vop",    32'(vopOut),    32'h0);
    for (int s = 0; s < SLOTS; s++) noteOnBySlot[s] = 1'b0;
    watchSlot(3);
    runRounds(1);
    expectVisit(1'b0, 16'h0000);
    checkLog("idle_slot3");

    $display("[TB] attack/decay/sustain on slot 5");
    writeCfg(0, 5'd5, 16'h4000);
    writeCfg(1, 5'd5, 16'h1000);
    writeCfg(2, 5'd5, 16'h8000);
    watchSlot(5);
    noteOnBySlot[5] = 1'b1;
    runRounds(13);
    expectVisit(1, 16'h4000); expectVisit(1, 16'h8000); expectVisit(1, 16'hC000);
    expectVisit(1, 16'hFFFF); expectVisit(1, 16'hEFFF); expectVisit(1, 16'hDFFF);
    expectVisit(1, 16'hCFFF); expectVisit(1, 16'hBFFF); expectVisit(1, 16'hAFFF);
    expectVisit(1, 16'h9FFF); expectVisit(1, 16'h8FFF); expectVisit(1, 16'h8000);
    expectVisit(1, 16'h8000);
    checkLog("ads_slot5");
    checkOutput("model_sustain_level", 32'(mLevel[5]), 32'h8000);
    checkOutput("model_sustain_state", 32'(mState[5]), 32'(M_SUSTAIN));

    $display("[TB] release on slot 5");
    writeCfg(3, 5'd5, 16'h3000);
    watchSlot(5);
    noteOnBySlot[5] = 1'b0;
    runRounds(4);
    expectVisit(1, 16'h5000); expectVisit(1, 16'h2000);
    expectVisit(0, 16'h0000); expectVisit(0, 16'h0000);
    checkLog("release_slot5");

    $display("[TB] retrigger from release");
    noteOnBySlot[5] = 1'b1;
    runRounds(13);
    watchSlot(5);
    noteOnBySlot[5] = 1'b0;
    runRounds(1);
    noteOnBySlot[5] = 1'b1;
    runRounds(3);
    expectVisit(1, 16'h5000); expectVisit(1, 16'h9000);
    expectVisit(1, 16'hD000); expectVisit(1, 16'hFFFF);
    checkLog("retrigger_slot5");
    checkOutput("model_retrigger_state", 32'(mState[5]), 32'(M_DECAY));

    $display("[TB] instant rates on slot 9");
    writeCfg(2, 5'd9, 16'h1234);
    watchSlot(9);
    noteOnBySlot[9] = 1'b1;
    runRounds(3);
    noteOnBySlot[9] = 1'b0;
    runRounds(2);
    expectVisit(1, 16'hFFFF); expectVisit(1, 16'h1234); expectVisit(1, 16'h1234);
    expectVisit(0, 16'h0000); expectVisit(0, 16'h0000);
    checkLog("instant_slot9");

    $display("[TB] rise coinciding with attack write on slot 20");
    watchSlot(20);
    noteOnBySlot[20] = 1'b1;
    alignTo(20);
    writeCfg(0, 5'd20, 16'h0100);
    alignTo(25);
    runRounds(1);
    expectVisit(1, 16'hFFFF); expectVisit(1, 16'h0000);
    checkLog("same_edge_slot20");

    $display("[TB] sustain rewrite on slot 5");
    runRounds(13);
    watchSlot(5);
    writeCfg(2, 5'd5, 16'h2000);
    runCycles(SLOTS - 1);
    expectVisit(1, 16'h2000);
    checkLog("sustain_rewrite_slot5");

    $display("[TB] reset mid-attack on slot 12");
    writeCfg(0, 5'd12, 16'h1000);
    watchSlot(12);
    noteOnBySlot[12] = 1'b1;
    runRounds(3);
    expectVisit(1, 16'h1000); expectVisit(1, 16'h2000); expectVisit(1, 16'h3000);
    checkLog("attack_slot12");
    for (int s = 0; s < SLOTS; s++) noteOnBySlot[s] = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 16'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 16'd0);
    watchSlot(12);
    runRounds(1);
    expectVisit(0, 16'h0000);
    checkLog("post_reset_slot12");

    runCycles(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/stage_envelope_generator.md
Name: stage_envelope_generator

Overview:
- Pipeline stage directly downstream of the phase accumulator stage.
- Consumes the time-multiplexed phase, note-on flag and voice-operator ID stream.
- Runs one ADSR envelope per voice-operator and emits a 16-bit envelope level aligned with the passed-through phase, for the waveform/amplitude stage.
- Per-operator envelope state is held in RAM arrays and updated read-modify-write, one operator per clock.

Parameters:
NUM_VOICES, 8, number of voices; note-on is per voice
NUM_OPERATORS, 4, operators per voice
NUM_VOICE_OPERATORS, NUM_VOICES*NUM_OPERATORS, depth of all per-operator arrays
VOP_ID_WIDTH, $clog2(NUM_VOICE_OPERATORS), width of voice-operator IDs

Ports:
i_Clock  in  1  clock
i_Reset_n  in  1  synchronous, active-low reset
i_Phase  in  16  phase from accumulator stage
i_NoteOn  in  1  voice note-on for this operator
i_VoiceOperator  in  VOP_ID_WIDTH  ID of current slot
o_Phase  out  16  i_Phase delayed 2 clocks
o_Envelope  out  16  unsigned envelope level for this slot
o_VoiceOperator  out  VOP_ID_WIDTH  ID delayed 2 clocks
o_EnvelopeActive  out  1  1 when slot state is not IDLE
i_AttackConfigWriteEnable  in  1  write attack rate
i_DecayConfigWriteEnable  in  1  write decay rate
i_SustainConfigWriteEnable  in  1  write sustain level
i_ReleaseConfigWriteEnable  in  1  write release rate
i_ConfigWriteAddr  in  VOP_ID_WIDTH  target operator
i_ConfigWriteData  in  16  config value

Behaviour:
- Reset is synchronous, active-low, sampled on the i_Clock edge:
  - all outputs go to 0.
  - every operator goes to state IDLE, level 0, previous-note-on 0.
  - all config registers go to 0.
  - in-flight pipeline data is discarded.
- Latency is 2 clocks:
  - Clock 1 registers the per-operator state, level, previous note-on, config and the inputs.
  - Clock 2 registers the outputs and writes the new state/level back to the arrays at the Clock-1 operator ID.
- Feedback constraint: the same ID must not appear on consecutive cycles; a back-to-back repeat reads the stale value (undefined envelope).
- Config writes land on the clock edge. A slot whose Clock-1 read occurs on a later edge uses the new value.
- Edge detection: rise = i_NoteOn & ~prev; fall = ~i_NoteOn & prev. prev is updated with i_NoteOn on every visit.
- States are IDLE, ATTACK, DECAY, SUSTAIN, RELEASE, evaluated in priority order:
  - rise (any state) -> ATTACK. Level is kept (retrigger, no click).
  - fall in ATTACK, DECAY or SUSTAIN -> RELEASE.
  - ATTACK: level += attack. On saturation at 0xFFFF or above, level = 0xFFFF and -> DECAY.
  - DECAY: level -= decay. If the result is <= sustain (unsigned compare, no wrap), level = sustain and -> SUSTAIN.
  - SUSTAIN: level = sustain. This tracks sustain rewrites.
  - RELEASE: level -= release. If the result would underflow or equal 0, level = 0 and -> IDLE.
  - IDLE: level 0, hold.
- A rate of 0 means instant:
  - attack 0 reaches 0xFFFF in one visit.
  - decay 0 jumps to sustain.
  - release 0 jumps to 0.
- Arithmetic uses 17-bit intermediates; saturation is explicit and never wraps.
- Sustain of 0xFFFF: DECAY goes to SUSTAIN on its first visit.
- Simultaneous rise and config write to the same slot in one edge: the old config applies on this visit.
- o_EnvelopeActive is computed from the post-update state.

Decomposition:
- synth package holds:
  - envelope_state_t (3-bit enum).
  - ENVELOPE_MAX = 16'hFFFF.
  - the VOP ID typedef.
  - getVoiceID().
- Sub-module envelope_next_state (combinational):
  - inputs: state, level, rise, fall, attack, decay, sustain, release.
  - outputs: next state and next level.
  - It is unit-testable standalone.

Test Plan:
1. Reset held low 2 clocks with stimulus active -> all outputs 0; after release, slot 3 with i_NoteOn=0 -> o_Envelope=0, o_EnvelopeActive=0.
2. Slot 5, attack=0x4000, decay=0x1000, sustain=0x8000, NoteOn held 1, round-robin over 32 slots:
   - visits 1-4 -> levels 0x4000, 0x8000, 0xC000, 0xFFFF (DECAY).
   - then 0xEFFF, 0xDFFF ... down to 0x8000, then held (SUSTAIN).
   - o_Phase and o_VoiceOperator equal the inputs delayed exactly 2 clocks.
3. NoteOn falls at 0x8000 with release=0x3000 -> 0x5000, 0x2000, 0x0000 (IDLE, active=0).
4. Retrigger: NoteOn 1->0->1 while RELEASE at 0x5000 with attack=0x4000 -> 0x9000 next visit, state ATTACK.
5. All rates 0, sustain=0x1234:
   - rise -> 0xFFFF, then 0x1234 on next visit.
   - fall -> 0 on next visit.
6. Rewrite sustain to 0x2000 during SUSTAIN -> o_Envelope=0x2000 on that slot's next visit; asserting reset mid-attack -> level 0 and IDLE on next visit.
